fp_round_pack: RTL

- Rounding/packing stage directly downstream of the FP add/sub normalizer.
- Consumes the normalized sign, exponent, 23-bit mantissa and GRS bits, then applies the RISC-V rounding mode.
- Handles mantissa-carry renormalization, overflow saturation, zero/NaN/Inf bypass and IEEE-754 exception flags.
- Produces a packed binary32 result plus fflags through a 2-stage valid/ready pipeline feeding the FPU writeback mux.

---
 rtl/fp_round_pack.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fp_round_pack.sv
// IEEE-754 binary32 rounding/packing stage behind the FP add/sub normalizer.
// Stage 1 decides the rounding increment; stage 2 renormalizes, saturates and packs with fflags.
module fp_round_pack #(
    parameter logic [31:0] CANON_NAN   = 32'h7FC00000,
    parameter int          PIPE_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [22:0] in_mant,
    input  logic [2:0]  in_grs,
    input  logic        in_underflow,
    input  logic        in_special,
    input  logic [31:0] in_special_val,
    input  logic        in_special_nv,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_fflags
);

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    generate
        if (PIPE_STAGES != 2) begin : g_bad_pipe_stages
            $error("fp_round_pack supports only PIPE_STAGES = 2");
        end
    endgenerate

    logic        adv1;
    logic        in_fire;
    logic        inc_d;
    logic [23:0] sum_d;
    logic        tiny_d;

    logic        s1_valid_q;
    logic        s1_sign_q;
    logic [7:0]  s1_exp_q;
    logic [23:0] s1_sum_q;
    logic        s1_inexact_q;
    logic        s1_tiny_q;
    logic [2:0]  s1_rm_q;
    logic        s1_special_q;
    logic [31:0] s1_special_val_q;
    logic        s1_special_nv_q;

    logic [7:0]  exp_r;
    logic        ovf;
    logic        rm_invalid;
    logic [31:0] s2_result_d;
    logic [4:0]  s2_fflags_d;
    logic        s2_valid_q;
    logic [31:0] s2_result_q;
    logic [4:0]  s2_fflags_q;

    assign adv1      = ~s2_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | adv1;
    assign in_fire   = in_valid & in_ready & ~flush;
    assign out_valid = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_fflags = s2_fflags_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        inc_d = 1'b0;
        unique case (in_rm)
            RM_RNE:  inc_d = in_grs[2] & (in_grs[1] | in_grs[0] | in_mant[0]);
            RM_RDN:  inc_d = in_sign & (|in_grs);
            RM_RUP:  inc_d = ~in_sign & (|in_grs);
            RM_RMM:  inc_d = in_grs[2];
            default: inc_d = 1'b0;
        endcase
    end

    assign sum_d  = {1'b0, in_mant} + {23'd0, inc_d};
    assign tiny_d = ((in_exp == 8'd0) && ((in_mant != 23'd0) || (|in_grs))) || in_underflow;

    // NOTE: datapath registers are reset as well, so outputs read zero right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q       <= 1'b0;
            s1_sign_q        <= 1'b0;
            s1_exp_q         <= 8'd0;
            s1_sum_q         <= 24'd0;
            s1_inexact_q     <= 1'b0;
            s1_tiny_q        <= 1'b0;
            s1_rm_q          <= 3'd0;
            s1_special_q     <= 1'b0;
            s1_special_val_q <= 32'd0;
            s1_special_nv_q  <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid_q <= 1'b0;
            end else if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_fire) begin
                s1_sign_q        <= in_sign;
                s1_exp_q         <= in_exp;
                s1_sum_q         <= sum_d;
                s1_inexact_q     <= |in_grs;
                s1_tiny_q        <= tiny_d;
                s1_rm_q          <= in_rm;
                s1_special_q     <= in_special;
                s1_special_val_q <= in_special_val;
                s1_special_nv_q  <= in_special_nv;
            end
        end
    end

    // A carry out of the significand leaves sum[22:0] zero, so only the exponent needs bumping.
    assign exp_r      = s1_sum_q[23] ? (s1_exp_q + 8'd1) : s1_exp_q;
    assign ovf        = (s1_exp_q == 8'hFF) || (exp_r == 8'hFF);
    assign rm_invalid = (s1_rm_q > RM_RMM);

    always_comb begin
        s2_result_d = {s1_sign_q, exp_r, s1_sum_q[22:0]};
        s2_fflags_d = {3'b000, s1_tiny_q & s1_inexact_q, s1_inexact_q};
        if (s1_special_q) begin
            s2_result_d = s1_special_val_q;
            s2_fflags_d = {s1_special_nv_q, 4'b0000};
        end else if (rm_invalid) begin
            s2_result_d = CANON_NAN;
            s2_fflags_d = 5'b10000;
        end else if (ovf) begin
            s2_fflags_d = 5'b00101;
            unique case (s1_rm_q)
                RM_RTZ:  s2_result_d = {s1_sign_q, 31'h7F7FFFFF};
                RM_RDN:  s2_result_d = s1_sign_q ? 32'hFF800000 : 32'h7F7FFFFF;
                RM_RUP:  s2_result_d = s1_sign_q ? 32'hFF7FFFFF : 32'h7F800000;
                default: s2_result_d = {s1_sign_q, 31'h7F800000};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= 32'd0;
            s2_fflags_q <= 5'd0;
        end else begin
            if (flush) begin
                s2_valid_q <= 1'b0;
            end else if (adv1) begin
                s2_valid_q <= s1_valid_q;
            end
            if (adv1 && s1_valid_q && !flush) begin
                s2_result_q <= s2_result_d;
                s2_fflags_q <= s2_fflags_d;
            end
        end
    end

endmodule
